rx_jitter_buffer: RTL
=====================

# rx_jitter_buffer

Receive-side audio jitter buffer between the packet manager's decrypted-sample output and the I2S controller's DAC input. Absorbs bursty radio delivery of decrypted 16-bit samples and plays them out at the steady I2S pace via a valid/ready handshake. Holds playback until a prefill level is reached, inserts silence on underrun, drops on overflow, and keeps saturating error counters for debug.

## Interface
- DEPTH, 64: FIFO entries; power of two, at least 4.
- PREFILL, 16: level that must be reached before playback starts; 1 ≤ PREFILL ≤ DEPTH.
- AW, $clog2(DEPTH): derived; not overridden.
- clk  in  1  system clock, 12 MHz.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  one-cycle pulse; empties the buffer (driven on push_to_talk rising edge).
- wr_data  in  16  decrypted audio sample.
- wr_valid  in  1  one-cycle strobe; the sample is offered to the FIFO. There is no backpressure.
- dac_data  out  16  sample offered to the I2S DAC.
- dac_valid  out  1  dac_data is valid.
- dac_ready  in  1  I2S consumes dac_data this cycle.
- level  out  AW+1  current FIFO occupancy, 0..DEPTH.
- playing  out  1  high in PLAY state.
- underrun_cnt  out  16  saturating count of underrun events.
- overflow_cnt  out  16  saturating count of dropped writes.

## Operation
- **States:** FILL and PLAY.
  - FILL: every handshake loads silence (16'h0000) into dac_data.
  - PLAY: every handshake loads the FIFO head and pops it.
- **FILL → PLAY:** at the edge where the registered level ≥ PREFILL.
- **PLAY → FILL on underrun:** a handshake occurs while level == 0.
  - dac_data loads 0.
  - underrun_cnt increments.
- **Write acceptance:** a write is accepted when wr_valid and level < DEPTH, using the pre-edge level.
  - A write on full is dropped and overflow_cnt increments, even if a pop occurs the same cycle.
- **Level update:** +1 for an accepted write, −1 for a pop, unchanged when both occur.
- **Pointers:** AW bits, natural wrap-around from DEPTH−1 to 0.
- **flush priority:** flush overrides everything in its cycle.
  - Pointers and level go to 0 and state goes to FILL.
  - A coincident write is discarded and is not counted as an overflow.
  - dac_data loads 0 if a handshake coincides.
- **Counters:** saturate at 16'hFFFF. Only reset clears them; flush does not.
- **dac_valid:** stays 0 during the reset cycle, goes to 1 at the first edge after reset deassertion, then stays high. The buffer always offers a sample, silence or audio.

## Timing
- **Reset values:**
  - dac_data=0, dac_valid=0, level=0, playing=0, underrun_cnt=0, overflow_cnt=0.
  - State FILL, pointers 0.
- **Output register:** dac_data is registered and changes only at an edge where dac_valid && dac_ready, or at reset. No combinational path from dac_ready to dac_data.
- **Write-to-output latency:** a sample written at edge N is at the FIFO head after edge N. The earliest it can appear on dac_data is after the first handshake edge ≥ N+1. There is no write-to-read bypass.
- **Prefill transition:**
  - level reaches PREFILL at edge N.
  - playing=1 after edge N+1.
  - The first audio sample loads at the first handshake edge ≥ N+2.
  - Handshakes at or before N+1 load silence.
- **Underrun:** playing drops after the underrun edge. Refill to PREFILL is required before audio resumes.
- **RAM read path:** the read address equals the pre-edge read pointer. A synchronous read is allowed only if the next head is prefetched so that the latency above holds.

## Structure
- **Shared package (voxguard_pkg):**
  - state enum jb_state_t {JB_FILL, JB_PLAY}
  - SILENCE_SAMPLE = 16'h0000
  - AUDIO_W = 16
  - CNT_W = 16
- **Sub-module jb_ram:**
  - DEPTH×16 simple dual-port memory, one write port and one read port.
  - No reset on its contents.
- **Top-level integration:**
  - Instantiated in the top level between packet_manager.dac_data_out/dac_data_valid and i2s_controller.dac_data_in/dac_data_valid/dac_ready.
  - flush is generated from the push_to_talk rising edge.

## Test plan
- **Reset:** assert rst mid-stream with level=10 → all outputs return to the reset values immediately; dac_valid=1 one cycle after release.
- **Prefill (DEPTH=64, PREFILL=16):**
  - Stimulus: write 16 samples 16'h0001..16'h0010 while dac_ready pulses every 8 cycles.
  - Required: dac_data stays 0 until playing=1; then the DAC receives 0x0001, 0x0002, ... in order, with level decrementing by 1 per handshake.
- **Underrun:**
  - Stimulus: after the prefill test, stop writing and drain all samples, then apply one more handshake.
  - Required: dac_data=0, underrun_cnt=1, playing=0.
  - Further handshakes give 0 with the counter unchanged until refill to PREFILL.
- **Overflow:**
  - Stimulus: write 70 samples with dac_ready=0.
  - Required: level=64, overflow_cnt=6; 64 samples are later read back in order and samples 65–70 never appear.
- **Simultaneous events:**
  - Stimulus 1: at level=64, write and handshake in the same cycle. Required: write dropped, level=63, overflow_cnt+1.
  - Stimulus 2: at level=5 in PLAY, write and handshake. Required: level stays 5.
- **Flush and wrap:**
  - Stimulus: stream 200 samples (pointers wrap 3×) at a steady rate, then pulse flush coincident with a write.
  - Required: no data corruption across wraps; after flush level=0, playing=0, counters unchanged, and the flushed-cycle write is absent from later output.

Source files
------------

// File: rtl/voxguard_pkg.sv
`default_nettype none
// ============================================================================
// Package     : voxguard_pkg
// Description : Shared types and constants for the receive audio path
//               (jitter buffer state, sample/counter widths, silence value).
// Revision    : 1.0 - initial release
// ============================================================================
package voxguard_pkg;

  localparam int AUDIO_W = 16;
  localparam int CNT_W   = 16;

  localparam logic [AUDIO_W-1:0] SILENCE_SAMPLE = 16'h0000;

  // FILL: holding playback until the prefill level is reached.
  // PLAY: draining the FIFO towards the DAC.
  typedef enum logic [0:0] {
    JB_FILL = 1'b0,
    JB_PLAY = 1'b1
  } jb_state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rx_jitter_buffer_if.sv
`default_nettype none
// ============================================================================
// Interface   : rx_jitter_buffer_if
// Description : Sample-in strobe and DAC valid/ready bus of the jitter
//               buffer. master = source/sink side, slave = the buffer.
// Revision    : 1.0 - initial release
// ============================================================================
interface rx_jitter_buffer_if;
  import voxguard_pkg::*;

  logic [AUDIO_W-1:0] wr_data;
  logic               wr_valid;
  logic [AUDIO_W-1:0] dac_data;
  logic               dac_valid;
  logic               dac_ready;

  modport master (
    output wr_data,
    output wr_valid,
    output dac_ready,
    input  dac_data,
    input  dac_valid
  );

  modport slave (
    input  wr_data,
    input  wr_valid,
    input  dac_ready,
    output dac_data,
    output dac_valid
  );

endinterface
`default_nettype wire

// File: rtl/rx_jitter_buffer_jb_ram.sv
`default_nettype none
// ============================================================================
// Module      : jb_ram
// Description : DEPTH x WIDTH simple dual-port storage. One synchronous write
//               port, one asynchronous read port so the FIFO head is visible
//               the cycle after it is written. Contents are not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module jb_ram #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Write port: store the accepted sample at the write pointer.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/rx_jitter_buffer.sv
`default_nettype none
// ============================================================================
// Module      : rx_jitter_buffer
// Description : Receive audio jitter buffer. Bursty decrypted samples are
//               queued and played out to the I2S DAC over valid/ready. Output
//               is silence until PREFILL samples are buffered; an empty FIFO
//               at a DAC handshake is an underrun (silence, back to FILL);
//               writes on a full FIFO are dropped. Both events are tallied
//               in saturating counters. flush empties the buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module rx_jitter_buffer
  import voxguard_pkg::*;
#(
  parameter  int DEPTH   = 64,
  parameter  int PREFILL = 16,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_flush,
  rx_jitter_buffer_if.slave    bus,
  output logic [AW:0]          o_level,
  output logic                 o_playing,
  output logic [CNT_W-1:0]     o_underrun_cnt,
  output logic [CNT_W-1:0]     o_overflow_cnt
);

  localparam logic [AW:0]   c_LVL_FULL    = (AW+1)'(DEPTH);
  localparam logic [AW:0]   c_LVL_PREFILL = (AW+1)'(PREFILL);
  localparam logic [AW:0]   c_LVL_ONE     = (AW+1)'(1);
  localparam logic [AW-1:0] c_PTR_ONE     = AW'(1);

  jb_state_t          r_state;
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [AW:0]        r_level;
  logic [AUDIO_W-1:0] r_dac_data;
  logic               r_dac_valid;
  logic [CNT_W-1:0]   r_underrun_cnt;
  logic [CNT_W-1:0]   r_overflow_cnt;

  logic [AUDIO_W-1:0] w_rd_data;
  logic               w_hs;
  logic               w_full;
  logic               w_empty;
  logic               w_wr_acc;
  logic               w_wr_drop;
  logic               w_pop;
  logic               w_underrun;

  // Event decode; flush masks every event in its cycle, including the
  // overflow tally of a coincident write on full.
  assign w_hs       = r_dac_valid & bus.dac_ready;
  assign w_full     = (r_level == c_LVL_FULL);
  assign w_empty    = (r_level == '0);
  assign w_wr_acc   = bus.wr_valid & ~w_full & ~i_flush;
  assign w_wr_drop  = bus.wr_valid &  w_full & ~i_flush;
  assign w_pop      = w_hs & (r_state == JB_PLAY) & ~w_empty & ~i_flush;
  assign w_underrun = w_hs & (r_state == JB_PLAY) &  w_empty & ~i_flush;

  jb_ram #(
    .DEPTH (DEPTH),
    .WIDTH (AUDIO_W),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_wr_acc),
    .i_waddr (r_wr_ptr),
    .i_wdata (bus.wr_data),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rd_data)
  );

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      if (w_wr_acc && !w_pop) begin
        r_level <= r_level + c_LVL_ONE;
      end else if (!w_wr_acc && w_pop) begin
        r_level <= r_level - c_LVL_ONE;
      end
    end
  end

  // FILL/PLAY control: start once the registered level reaches PREFILL,
  // fall back to FILL on underrun or flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= JB_FILL;
    end else if (i_flush || w_underrun) begin
      r_state <= JB_FILL;
    end else if ((r_state == JB_FILL) && (r_level >= c_LVL_PREFILL)) begin
      r_state <= JB_PLAY;
    end
  end

  // DAC output register: loads only on a handshake; audio only when popping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dac_data <= SILENCE_SAMPLE;
    end else if (w_hs) begin
      r_dac_data <= w_pop ? w_rd_data : SILENCE_SAMPLE;
    end
  end

  // dac_valid rises on the first edge out of reset and then stays high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dac_valid <= 1'b0;
    end else begin
      r_dac_valid <= 1'b1;
    end
  end

  // Debug counters; survive flush, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_underrun_cnt <= '0;
      r_overflow_cnt <= '0;
    end else begin
      if (w_underrun) begin
        r_underrun_cnt <= sat_inc(r_underrun_cnt);
      end
      if (w_wr_drop) begin
        r_overflow_cnt <= sat_inc(r_overflow_cnt);
      end
    end
  end

  assign bus.dac_data   = r_dac_data;
  assign bus.dac_valid  = r_dac_valid;
  assign o_level        = r_level;
  assign o_playing      = (r_state == JB_PLAY);
  assign o_underrun_cnt = r_underrun_cnt;
  assign o_overflow_cnt = r_overflow_cnt;

endmodule
`default_nettype wire
